rv_exec_core: RTL and testbench

- Parametrised multi-cycle integer execute core: the successor to the single-cycle ALU plus register-file datapath.
- Accepts one RV32I/RV64I-style R-type or OP-IMM instruction through a valid/ready handshake.
- Reads operands from an internal register file (x0 hardwired to zero) and executes.
- Shifts run on an iterative 1-bit-per-cycle shifter.
- Writes back to the register file and reports a one-cycle result pulse; illegal encodings are flagged.

---
 rtl/rv_exec_core_if.sv | 23 ++
 rtl/rv_exec_core.sv | 165 ++++++++++++++++
 tb/tb_rv_exec_core.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_exec_core_if.sv
// Instruction/result handshake bundle for rv_exec_core.
// master drives instructions and observes retirement; slave is the core.
interface rv_exec_core_if #(
  parameter int XLEN = 32
);
  logic            instr_valid;
  logic [31:0]     instr;
  logic            instr_ready;
  logic            result_valid;
  logic [4:0]      result_rd;
  logic [XLEN-1:0] result_data;
  logic            illegal;

  modport master (
    output instr_valid, instr,
    input  instr_ready, result_valid, result_rd, result_data, illegal
  );

  modport slave (
    input  instr_valid, instr,
    output instr_ready, result_valid, result_rd, result_data, illegal
  );
endinterface

// File: rtl/rv_exec_core.sv
// Multi-cycle RV32I/RV64I R-type and OP-IMM execute core with internal register file
// and an iterative 1-bit-per-cycle shifter.
//
// state | meaning
// IDLE  | ready for an instruction; decode, snapshot operands on accept
// SHIFT | iterative shift, one bit per cycle, counter runs down to 1
// WB    | result_valid or illegal pulse; register write at the edge ending WB
module rv_exec_core #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  rv_exec_core_if.slave   bus,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);
  localparam int SHW = $clog2(XLEN);
  localparam int AW  = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, WB} state_t;

  state_t          state;
  logic [XLEN-1:0] regs [NREGS];

  logic            result_valid_q;
  logic            illegal_q;
  logic [4:0]      result_rd_q;
  logic [XLEN-1:0] result_data_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] sh_val;
  logic [SHW-1:0]  sh_cnt;
  logic            sh_left;
  logic            sh_fill;

  function automatic logic in_range(input logic [4:0] idx);
    return {27'd0, idx} < 32'(NREGS);
  endfunction

  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [11:0]     imm;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] rs1_val, rs2_val;

  assign opcode  = bus.instr[6:0];
  assign rd      = bus.instr[11:7];
  assign funct3  = bus.instr[14:12];
  assign rs1     = bus.instr[19:15];
  assign rs2     = bus.instr[24:20];
  assign funct7  = bus.instr[31:25];
  assign imm     = bus.instr[31:20];
  assign imm_ext = {{(XLEN-12){imm[11]}}, imm};
  assign rs1_val = in_range(rs1) ? regs[rs1[AW-1:0]] : '0;
  assign rs2_val = in_range(rs2) ? regs[rs2[AW-1:0]] : '0;

  logic            is_r, is_i, alt;
  logic            dec_legal, dec_shift;
  logic [11:0]     hi_mask;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] op_b, alu_res;

  always_comb begin
    is_r      = (opcode == 7'b0110011);
    is_i      = (opcode == 7'b0010011);
    op_b      = is_r ? rs2_val : imm_ext;
    alt       = is_r ? funct7[5] : ((funct3 == 3'b101) && imm[10]);
    shamt     = is_r ? rs2_val[SHW-1:0] : imm[SHW-1:0];
    hi_mask   = ~((12'd1 << SHW) - 12'd1);
    dec_legal = 1'b0;
    dec_shift = 1'b0;
    alu_res   = '0;
    if (funct3 == 3'b101)
      hi_mask[10] = 1'b0;
    if (is_r)
      dec_legal = (funct7 == 7'b0000000) ||
                  ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
    else if (is_i)
      dec_legal = ((funct3 == 3'b001) || (funct3 == 3'b101)) ? ((imm & hi_mask) == 12'd0) : 1'b1;
    if (!in_range(rd) || !in_range(rs1) || (is_r && !in_range(rs2)))
      dec_legal = 1'b0;
    case (funct3)
      3'b000: alu_res = (is_r && alt) ? (rs1_val - op_b) : (rs1_val + op_b);
      3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1_val) < $signed(op_b))};
      3'b011: alu_res = {{(XLEN-1){1'b0}}, (rs1_val < op_b)};
      3'b100: alu_res = rs1_val ^ op_b;
      3'b110: alu_res = rs1_val | op_b;
      3'b111: alu_res = rs1_val & op_b;
      default: begin
        // shift by zero retires the unshifted operand without entering SHIFT
        alu_res   = rs1_val;
        dec_shift = (shamt != '0);
      end
    endcase
  end

  logic [XLEN-1:0] sh_next;
  assign sh_next = sh_left ? {sh_val[XLEN-2:0], 1'b0} : {sh_fill, sh_val[XLEN-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      result_valid_q <= 1'b0;
      illegal_q      <= 1'b0;
      result_rd_q    <= '0;
      result_data_q  <= '0;
      rd_q           <= '0;
      sh_val         <= '0;
      sh_cnt         <= '0;
      sh_left        <= 1'b0;
      sh_fill        <= 1'b0;
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.instr_valid) begin
            rd_q <= rd;
            if (dec_legal && dec_shift) begin
              sh_val  <= rs1_val;
              sh_cnt  <= shamt;
              sh_left <= (funct3 == 3'b001);
              sh_fill <= alt && (funct3 == 3'b101) && rs1_val[XLEN-1];
              state   <= SHIFT;
            end else begin
              result_valid_q <= dec_legal;
              illegal_q      <= !dec_legal;
              result_rd_q    <= dec_legal ? rd : 5'd0;
              result_data_q  <= (dec_legal && (rd != 5'd0)) ? alu_res : '0;
              state          <= WB;
            end
          end
        end
        SHIFT: begin
          sh_val <= sh_next;
          sh_cnt <= sh_cnt - 1'b1;
          if (sh_cnt == SHW'(1)) begin
            result_valid_q <= 1'b1;
            result_rd_q    <= rd_q;
            result_data_q  <= (rd_q != 5'd0) ? sh_next : '0;
            state          <= WB;
          end
        end
        WB: begin
          if (result_valid_q && (result_rd_q != 5'd0))
            regs[result_rd_q[AW-1:0]] <= result_data_q;
          result_valid_q <= 1'b0;
          illegal_q      <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.instr_ready  = (state == IDLE) && !rst;
  assign bus.result_valid = result_valid_q;
  assign bus.illegal      = illegal_q;
  assign bus.result_rd    = result_rd_q;
  assign bus.result_data  = result_data_q;

  assign dbg_data = ((dbg_addr != 5'd0) && in_range(dbg_addr)) ? regs[dbg_addr[AW-1:0]] : '0;
endmodule

// File: tb/tb_rv_exec_core.sv
// Lockstep bench for a 32-bit/32-register core and a 64-bit/16-register core,
// with a queue scoreboard fed by a reference model at each accept.
module tb_rv_exec_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  dbg_addr = 5'd0;
  logic [31:0] dbg_a;
  logic [63:0] dbg_b;
  logic        drv_valid = 1'b0;
  logic [31:0] drv_instr = 32'd0;

  rv_exec_core_if #(.XLEN(32)) ba ();
  rv_exec_core_if #(.XLEN(64)) bb ();

  assign ba.instr_valid = drv_valid;
  assign ba.instr       = drv_instr;
  assign bb.instr_valid = drv_valid;
  assign bb.instr       = drv_instr;

  rv_exec_core #(.XLEN(32), .NREGS(32)) dut_a (
    .clk(clk), .rst(rst), .bus(ba), .dbg_addr(dbg_addr), .dbg_data(dbg_a));
  rv_exec_core #(.XLEN(64), .NREGS(16)) dut_b (
    .clk(clk), .rst(rst), .bus(bb), .dbg_addr(dbg_addr), .dbg_data(dbg_b));

  always #5 clk = ~clk;

  typedef struct {
    bit          ill;
    logic [4:0]  rd;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t        qa[$], qb[$];
  exp_t        ea, eb;
  int          checks = 0, errors = 0;
  int          cyc = 0;
  int          pulses_a = 0, pulses_b = 0;
  logic [63:0] ma [32];
  logic [63:0] mb [32];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic void model(input int xl, input int nr, input logic [31:0] ins,
                                input logic [63:0] r1, input logic [63:0] r2,
                                output bit ill, output logic [63:0] res, output int lat);
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [11:0] im;
    logic [63:0] mask, a, b, sa, sb, imm;
    int          shw, amt;
    bit          sub_sra;
    opc  = ins[6:0];
    f3   = ins[14:12];
    f7   = ins[31:25];
    im   = ins[31:20];
    mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    shw  = (xl == 64) ? 6 : 5;
    a    = r1 & mask;
    imm  = {{52{im[11]}}, im} & mask;
    b    = (opc == 7'b0110011) ? (r2 & mask) : imm;
    sa   = (xl == 64) ? a : {{32{a[31]}}, a[31:0]};
    sb   = (xl == 64) ? b : {{32{b[31]}}, b[31:0]};
    ill = 0; res = '0; lat = 0; amt = 0; sub_sra = 0;
    if (int'(ins[11:7]) >= nr || int'(ins[19:15]) >= nr) ill = 1;
    if (opc == 7'b0110011) begin
      if (int'(ins[24:20]) >= nr) ill = 1;
      if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) ill = 1;
      sub_sra = (f7 == 7'h20);
      amt = int'(b[5:0]) & (xl - 1);
    end else if (opc == 7'b0010011) begin
      amt = int'(ins[25:20]) & (xl - 1);
      sub_sra = (f3 == 3'd5) && ins[30];
      if (f3 == 3'd1 || f3 == 3'd5)
        for (int k = shw; k < 12; k++)
          if (im[k] && !(k == 10 && f3 == 3'd5)) ill = 1;
    end else begin
      ill = 1;
    end
    case (f3)
      3'd0: res = sub_sra ? a - b : a + b;
      3'd1: begin res = a << amt; lat = amt; end
      3'd2: res = ($signed(sa) < $signed(sb)) ? 64'd1 : 64'd0;
      3'd3: res = (a < b) ? 64'd1 : 64'd0;
      3'd4: res = a ^ b;
      3'd5: begin res = sub_sra ? 64'($signed(sa) >>> amt) : (a >> amt); lat = amt; end
      3'd6: res = a | b;
      default: res = a & b;
    endcase
    res = res & mask;
    if (ill) begin res = '0; lat = 0; end
  endfunction

  task automatic issue(input logic [31:0] ins, input bit keep, input bit nopush, output int acc);
    int          n;
    exp_t        e;
    bit          ill;
    logic [63:0] res;
    int          lat;
    n = 0;
    @(negedge clk);
    while (!(ba.instr_ready && bb.instr_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 200) else begin errors++; $error("FAIL ready_timeout waited %0d want <200", n); end
    drv_instr = ins;
    drv_valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    if (!keep) drv_valid = 1'b0;
    if (!nopush) begin
      model(32, 32, ins, ma[ins[19:15]], ma[ins[24:20]], ill, res, lat);
      e.ill = ill; e.rd = ill ? 5'd0 : ins[11:7];
      e.data = (ins[11:7] == 5'd0) ? 64'd0 : res; e.cyc = acc + lat;
      qa.push_back(e);
      if (!ill && ins[11:7] != 5'd0) ma[ins[11:7]] = res;
      model(64, 16, ins, mb[ins[19:15]], mb[ins[24:20]], ill, res, lat);
      e.ill = ill; e.rd = ill ? 5'd0 : ins[11:7];
      e.data = (ins[11:7] == 5'd0) ? 64'd0 : res; e.cyc = acc + lat;
      qb.push_back(e);
      if (!ill && ins[11:7] != 5'd0) mb[ins[11:7]] = res;
    end
  endtask

  task automatic go(input logic [31:0] ins);
    int acc;
    issue(ins, 1'b0, 1'b0, acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || !ba.instr_ready || !bb.instr_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 300) else begin errors++; $error("FAIL drain_timeout waited %0d want <300", n); end
  endtask

  task automatic chk_dbg(input logic [4:0] a, input logic [63:0] exp_a, input logic [63:0] exp_b,
                         input string tag);
    dbg_addr = a;
    #1;
    checks++;
    assert ({32'd0, dbg_a} === exp_a) else begin
      errors++; $error("FAIL %s dut_a x%0d got %h want %h", tag, a, dbg_a, exp_a);
    end
    checks++;
    assert (dbg_b === exp_b) else begin
      errors++; $error("FAIL %s dut_b x%0d got %h want %h", tag, a, dbg_b, exp_b);
    end
  endtask

  task automatic chk_bit(input logic got, input logic want, input string tag);
    checks++;
    assert (got === want) else begin errors++; $error("FAIL %s got %b want %b", tag, got, want); end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (ba.result_valid || ba.illegal)) begin
      pulses_a++;
      checks++;
      assert (qa.size() > 0) else begin
        errors++; $error("FAIL a_unexpected_pulse got rd %0d data %h want no pulse", ba.result_rd, ba.result_data);
      end
      if (qa.size() > 0) begin
        ea = qa.pop_front();
        checks += 3;
        assert (ba.illegal === ea.ill) else begin errors++; $error("FAIL a_illegal got %b want %b", ba.illegal, ea.ill); end
        assert (ba.result_valid === ~ea.ill) else begin errors++; $error("FAIL a_valid got %b want %b", ba.result_valid, ~ea.ill); end
        assert (cyc === ea.cyc) else begin errors++; $error("FAIL a_latency got cycle %0d want %0d", cyc, ea.cyc); end
        if (!ea.ill) begin
          checks += 2;
          assert (ba.result_rd === ea.rd) else begin errors++; $error("FAIL a_rd got %0d want %0d", ba.result_rd, ea.rd); end
          assert ({32'd0, ba.result_data} === ea.data) else begin errors++; $error("FAIL a_data got %h want %h", ba.result_data, ea.data); end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && (bb.result_valid || bb.illegal)) begin
      pulses_b++;
      checks++;
      assert (qb.size() > 0) else begin
        errors++; $error("FAIL b_unexpected_pulse got rd %0d data %h want no pulse", bb.result_rd, bb.result_data);
      end
      if (qb.size() > 0) begin
        eb = qb.pop_front();
        checks += 3;
        assert (bb.illegal === eb.ill) else begin errors++; $error("FAIL b_illegal got %b want %b", bb.illegal, eb.ill); end
        assert (bb.result_valid === ~eb.ill) else begin errors++; $error("FAIL b_valid got %b want %b", bb.result_valid, ~eb.ill); end
        assert (cyc === eb.cyc) else begin errors++; $error("FAIL b_latency got cycle %0d want %0d", cyc, eb.cyc); end
        if (!eb.ill) begin
          checks += 2;
          assert (bb.result_rd === eb.rd) else begin errors++; $error("FAIL b_rd got %0d want %0d", bb.result_rd, eb.rd); end
          assert (bb.result_data === eb.data) else begin errors++; $error("FAIL b_data got %h want %h", bb.result_data, eb.data); end
        end
      end
    end
  end

  initial begin
    int acc1, acc2, pa, pb;
    model_reset();
    // power-on reset state
    repeat (2) @(posedge clk);
    #1;
    chk_bit(ba.instr_ready, 1'b0, "por_ready_a");
    chk_bit(bb.instr_ready, 1'b0, "por_ready_b");
    chk_bit(ba.result_valid, 1'b0, "por_valid_a");
    chk_bit(bb.illegal, 1'b0, "por_illegal_b");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_bit(ba.instr_ready, 1'b1, "por_release_ready_a");
    chk_bit(bb.instr_ready, 1'b1, "por_release_ready_b");

    // mid-cycle reset clears preloaded registers
    go(i_ins(12'd7, 5'd0, 3'd0, 5'd1));
    drain();
    chk_dbg(5'd1, 64'd7, 64'd7, "preload");
    @(posedge clk);
    #2 rst = 1'b1;
    chk_dbg(5'd1, 64'd0, 64'd0, "rst_clear");
    chk_bit(ba.instr_ready, 1'b0, "rst_ready_a");
    chk_bit(bb.instr_ready, 1'b0, "rst_ready_b");
    @(posedge clk);
    #1;
    checks += 4;
    assert (ba.result_rd === 5'd0) else begin errors++; $error("FAIL rst_rd_a got %0d want 0", ba.result_rd); end
    assert (ba.result_data === 32'd0) else begin errors++; $error("FAIL rst_data_a got %h want 0", ba.result_data); end
    assert (bb.result_rd === 5'd0) else begin errors++; $error("FAIL rst_rd_b got %0d want 0", bb.result_rd); end
    assert (bb.result_data === 64'd0) else begin errors++; $error("FAIL rst_data_b got %h want 0", bb.result_data); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk_bit(ba.instr_ready, 1'b1, "rst_release_ready_a");
    chk_bit(bb.instr_ready, 1'b1, "rst_release_ready_b");

    // ALU ops on x1=2, x2=5
    go(i_ins(12'd2, 5'd0, 3'd0, 5'd1));
    go(i_ins(12'd5, 5'd0, 3'd0, 5'd2));
    go(r_ins(7'h00, 5'd1, 5'd2, 3'd0, 5'd3)); drain(); chk_dbg(5'd3, 64'd7, 64'd7, "add");
    go(r_ins(7'h20, 5'd1, 5'd2, 3'd0, 5'd3)); drain(); chk_dbg(5'd3, 64'd3, 64'd3, "sub");
    go(r_ins(7'h00, 5'd1, 5'd2, 3'd7, 5'd3)); drain(); chk_dbg(5'd3, 64'd0, 64'd0, "and");
    go(r_ins(7'h00, 5'd1, 5'd2, 3'd6, 5'd3)); drain(); chk_dbg(5'd3, 64'd7, 64'd7, "or");
    go(r_ins(7'h00, 5'd1, 5'd2, 3'd4, 5'd3)); drain(); chk_dbg(5'd3, 64'd7, 64'd7, "xor");

    // shifts
    go(i_ins(12'd1, 5'd0, 3'd0, 5'd2));
    go(i_ins(12'd31, 5'd2, 3'd1, 5'd2)); drain();
    chk_dbg(5'd2, 64'h8000_0000, 64'h8000_0000, "slli31");
    go(i_ins(12'h404, 5'd2, 3'd5, 5'd4)); drain();
    chk_dbg(5'd4, 64'hF800_0000, 64'h0800_0000, "srai4");
    go(r_ins(7'h00, 5'd0, 5'd2, 3'd5, 5'd5)); drain();
    chk_dbg(5'd5, 64'h8000_0000, 64'h8000_0000, "srl_by_x0");
    go(i_ins(12'd33, 5'd0, 3'd0, 5'd11));
    go(r_ins(7'h20, 5'd11, 5'd2, 3'd5, 5'd10)); drain();
    chk_dbg(5'd10, 64'hC000_0000, 64'd0, "sra_reg33");
    go(i_ins(12'd32, 5'd1, 3'd1, 5'd12)); drain();
    chk_dbg(5'd12, 64'd0, 64'h2_0000_0000, "slli32");

    // compares and immediates
    go(i_ins(12'hFFF, 5'd0, 3'd0, 5'd6)); drain();
    chk_dbg(5'd6, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "addi_m1");
    go(i_ins(12'hFFF, 5'd1, 3'd3, 5'd7)); drain(); chk_dbg(5'd7, 64'd1, 64'd1, "sltiu");
    go(r_ins(7'h00, 5'd1, 5'd6, 3'd2, 5'd8)); drain(); chk_dbg(5'd8, 64'd1, 64'd1, "slt");
    go(r_ins(7'h00, 5'd1, 5'd6, 3'd3, 5'd8)); drain(); chk_dbg(5'd8, 64'd0, 64'd0, "sltu");
    go(i_ins(12'd0, 5'd6, 3'd2, 5'd13));
    go(i_ins(12'h0F0, 5'd1, 3'd4, 5'd14));
    go(i_ins(12'h80F, 5'd6, 3'd7, 5'd15)); drain();
    chk_dbg(5'd15, 64'hFFFF_F80F, 64'hFFFF_FFFF_FFFF_F80F, "andi");

    // illegal encodings and x0
    go(r_ins(7'h20, 5'd1, 5'd2, 3'd7, 5'd3)); drain(); chk_dbg(5'd3, 64'd7, 64'd7, "illegal_keeps_x3");
    go(i_ins(12'd5, 5'd0, 3'd0, 5'd0)); drain(); chk_dbg(5'd0, 64'd0, 64'd0, "x0_write");
    go(32'h0000_007F);
    go(i_ins(12'h401, 5'd1, 3'd1, 5'd9));
    go(i_ins(12'h801, 5'd1, 3'd5, 5'd9));
    go(r_ins(7'h01, 5'd1, 5'd2, 3'd0, 5'd9)); drain();
    chk_dbg(5'd9, 64'd0, 64'd0, "illegal_no_write");
    go(i_ins(12'd9, 5'd0, 3'd0, 5'd16)); drain(); chk_dbg(5'd16, 64'd9, 64'd0, "rd16");
    go(r_ins(7'h00, 5'd1, 5'd20, 3'd0, 5'd17)); drain(); chk_dbg(5'd17, 64'd2, 64'd0, "rs1_20");

    // back-to-back with instr_valid held; the instruction word changes while not ready
    issue(i_ins(12'd3, 5'd0, 3'd0, 5'd1), 1'b1, 1'b0, acc1);
    drv_instr = r_ins(7'h00, 5'd1, 5'd1, 3'd0, 5'd2);
    issue(r_ins(7'h00, 5'd1, 5'd1, 3'd0, 5'd2), 1'b0, 1'b0, acc2);
    checks++;
    assert (acc2 - acc1 === 2) else begin errors++; $error("FAIL issue_interval got %0d want 2", acc2 - acc1); end
    drain();
    chk_dbg(5'd2, 64'd6, 64'd6, "b2b_add");

    // reset aborts an in-flight shift
    pa = pulses_a;
    pb = pulses_b;
    issue(i_ins(12'd20, 5'd1, 3'd1, 5'd9), 1'b0, 1'b1, acc1);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (25) @(negedge clk);
    checks += 2;
    assert (pulses_a === pa) else begin errors++; $error("FAIL abort_pulse_a got %0d want %0d", pulses_a, pa); end
    assert (pulses_b === pb) else begin errors++; $error("FAIL abort_pulse_b got %0d want %0d", pulses_b, pb); end
    chk_dbg(5'd9, 64'd0, 64'd0, "abort_x9");
    chk_dbg(5'd1, 64'd0, 64'd0, "abort_x1");

    // post-reset traffic, then full register sweep
    go(i_ins(12'hFF9, 5'd0, 3'd0, 5'd1));
    go(i_ins(12'd28, 5'd1, 3'd5, 5'd4));
    go(i_ins(12'h402, 5'd1, 3'd5, 5'd5));
    go(r_ins(7'h00, 5'd1, 5'd1, 3'd1, 5'd6));
    go(r_ins(7'h20, 5'd4, 5'd5, 3'd0, 5'd7));
    drain();
    for (int i = 0; i < 32; i++)
      chk_dbg(5'(i), ma[i], (i < 16) ? mb[i] : 64'd0, "sweep");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
